// File: rtl/perf_counter_reader_pkg.sv
// Shared types and constants for the performance counter reader.
package perf_reader_pkg;

  typedef enum logic [2:0] {IDLE, HDR, ISSUE, WAIT, PUSH, DONE} state_t;

  localparam logic [7:0] HEADER_MAGIC = 8'hC5;

  localparam logic [1:0] REC_STATS   = 2'd0;
  localparam logic [1:0] REC_SAMPLER = 2'd1;
  localparam logic [1:0] REC_TRACKER = 2'd2;

  localparam int DEF_LAST_IDX_0 = 17;
  localparam int DEF_LAST_IDX_1 = 15;
  localparam int DEF_LAST_IDX_2 = 55;

  localparam int COMM_EN_BIT = 24;

  // Header carries the record id and the number of words that follow.
  function automatic logic [31:0] make_header(input logic [1:0] sel, input logic [5:0] last);
    logic [6:0] cnt;
    cnt = {1'b0, last} + 7'd1;
    return {HEADER_MAGIC, 6'b0, sel, 9'b0, cnt};
  endfunction

endpackage

// File: rtl/perf_counter_reader_if.sv
// Command bus to the responder plus the valid/ready word stream to the host.
interface perf_counter_reader_if;
  logic [31:0] comm_o;
  logic [1:0]  select_data_record_o;
  logic [31:0] comm_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        last_o;

  modport master (
    output comm_o, select_data_record_o, data_o, valid_o, last_o,
    input  comm_i, ready_i
  );

  modport slave (
    input  comm_o, select_data_record_o, data_o, valid_o, last_o,
    output comm_i, ready_i
  );
endinterface

// File: rtl/perf_counter_reader.sv
// Sweeps one performance record over the command bus and streams
// a header plus every returned word to the host.
module perf_counter_reader
  import perf_reader_pkg::*;
#(
  parameter int LATENCY        = 2,
  parameter int LAST_IDX_0     = DEF_LAST_IDX_0,
  parameter int LAST_IDX_1     = DEF_LAST_IDX_1,
  parameter int LAST_IDX_2     = DEF_LAST_IDX_2,
  parameter int HAS_TRACKER    = 1,
  parameter int FREEZE_ON_READ = 1
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] sel_i,
  input  logic       count_en_i,
  perf_counter_reader_if.master bus,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t        state, next_state;
  logic [1:0]    sel_q;
  logic [5:0]    last_q, idx, cmd_idx, sel_last;
  logic [CW-1:0] wcnt;
  logic [31:0]   data_q, comm;
  logic          valid_q, last_flag_q, en_q, err_q;
  logic          sel_ok, accept, reject, hs;

  // Decode the requested record into its final index and validity.
  always_comb begin
    sel_ok   = 1'b1;
    sel_last = 6'(LAST_IDX_0);
    case (sel_i)
      REC_STATS:   sel_last = 6'(LAST_IDX_0);
      REC_SAMPLER: sel_last = 6'(LAST_IDX_1);
      REC_TRACKER: begin
        sel_last = 6'(LAST_IDX_2);
        sel_ok   = (HAS_TRACKER != 0);
      end
      default:     sel_ok = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic and start accept/reject decode.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    hs         = valid_q & bus.ready_i;
    unique case (state)
      IDLE: if (start_i) begin
        if (sel_ok) begin
          accept     = 1'b1;
          next_state = HDR;
        end else begin
          reject = 1'b1;
        end
      end
      HDR:   if (hs) next_state = ISSUE;
      ISSUE: next_state = WAIT;
      WAIT:  if (wcnt == '0) next_state = PUSH;
      PUSH:  if (hs) next_state = (idx == last_q) ? DONE : ISSUE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: record latch, index walk, latency count, output word capture.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sel_q       <= '0;
      last_q      <= '0;
      idx         <= '0;
      cmd_idx     <= '0;
      wcnt        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_flag_q <= 1'b0;
      en_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= reject;
      // Counters stay frozen for the whole sweep so 64-bit pairs read coherently.
      en_q  <= count_en_i & !((FREEZE_ON_READ != 0) && (next_state != IDLE));
      case (state)
        IDLE: if (accept) begin
          sel_q       <= sel_i;
          last_q      <= sel_last;
          idx         <= '0;
          data_q      <= make_header(sel_i, sel_last);
          valid_q     <= 1'b1;
          last_flag_q <= 1'b0;
        end
        HDR: if (hs) valid_q <= 1'b0;
        ISSUE: begin
          cmd_idx <= idx;
          wcnt    <= CW'(LATENCY - 1);
        end
        WAIT: begin
          if (wcnt == '0) begin
            data_q      <= bus.comm_i;
            valid_q     <= 1'b1;
            last_flag_q <= (idx == last_q);
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        PUSH: if (hs) begin
          valid_q     <= 1'b0;
          last_flag_q <= 1'b0;
          if (idx != last_q) idx <= idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Assemble the command word: enable bit plus index, all else zero.
  always_comb begin
    comm              = '0;
    comm[COMM_EN_BIT] = en_q;
    comm[5:0]         = cmd_idx;
  end

  assign bus.comm_o               = comm;
  assign bus.select_data_record_o = sel_q;
  assign bus.data_o               = data_q;
  assign bus.valid_o              = valid_q;
  assign bus.last_o               = last_flag_q;
  assign busy_o                   = (state != IDLE);
  assign done_o                   = (state == DONE);
  assign err_o                    = err_q;

endmodule

// File: tb/tb_perf_counter_reader.sv
// Directed bench for perf_counter_reader with a one-register responder model.
module tb_perf_counter_reader;

  logic       clk = 1'b0;
  logic       rst, start, count_en;
  logic [1:0] sel;
  logic       busy, done, err;
  logic       start_nt;
  logic [1:0] sel_nt;
  logic       busy_nt, done_nt, err_nt;

  int n_chk = 0;
  int n_fail = 0;

  logic [32:0] wq[$];
  int busy_cyc = 0, done_cnt = 0, err_cnt = 0, valid_cyc = 0;
  int err_nt_cnt = 0, busy_nt_cyc = 0, valid_nt_cyc = 0;

  perf_counter_reader_if bus ();
  perf_counter_reader_if bus_nt ();

  always #5 clk = ~clk;

  perf_counter_reader u_dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .sel_i(sel), .count_en_i(count_en),
    .bus(bus.master), .busy_o(busy), .done_o(done), .err_o(err)
  );

  perf_counter_reader #(.HAS_TRACKER(0)) u_dut_nt (
    .clock_i(clk), .reset_i(rst), .start_i(start_nt), .sel_i(sel_nt), .count_en_i(1'b0),
    .bus(bus_nt.master), .busy_o(busy_nt), .done_o(done_nt), .err_o(err_nt)
  );

  // Responder: registers the command word once and returns A000_0000|idx.
  always @(posedge clk) bus.comm_i <= 32'hA000_0000 | {26'b0, bus.comm_o[5:0]};
  assign bus_nt.comm_i  = '0;
  assign bus_nt.ready_i = 1'b1;

  // Monitor: collect accepted words and event counts away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid_o && bus.ready_i) wq.push_back({bus.last_o, bus.data_o});
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (bus.valid_o) valid_cyc++;
      if (err_nt) err_nt_cnt++;
      if (busy_nt) busy_nt_cyc++;
      if (bus_nt.valid_o) valid_nt_cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [1:0] s);
    sel   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, c;
    d0 = done_cnt;
    c  = 0;
    while (done_cnt == d0 && c < budget) begin
      tick();
      c++;
    end
    chk("done_pulses", done_cnt - d0, 1);
    tick();
  endtask

  task automatic check_sweep(input int base, input int s, input int n);
    logic [31:0] hdr;
    hdr = {8'hC5, 6'b0, 2'(s), 9'b0, 7'(n)};
    chk("nwords", wq.size() - base, n + 1);
    if (wq.size() >= base + n + 1) begin
      chk("hdr", wq[base][31:0], hdr);
      chk("hdr_last", 32'(wq[base][32]), 0);
      for (int i = 0; i < n; i++) begin
        chk("word", wq[base+1+i][31:0], 32'hA000_0000 | 32'(i));
        chk("word_last", 32'(wq[base+1+i][32]), (i == n - 1) ? 1 : 0);
      end
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_comm", bus.comm_o, 0);
    chk("rst_select", 32'(bus.select_data_record_o), 0);
    chk("rst_data", bus.data_o, 0);
    chk("rst_valid", 32'(bus.valid_o), 0);
    chk("rst_last", 32'(bus.last_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
  endtask

  initial begin
    int b0, q0, e0, v0, stall, frz_bad, seen, c;

    rst = 1'b1; start = 1'b1; sel = 2'd0; count_en = 1'b0; bus.ready_i = 1'b1;
    start_nt = 1'b0; sel_nt = 2'd0;

    // Reset held with start asserted.
    tick(); tick(); tick();
    @(negedge clk);
    check_reset_outputs();
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Record 0 sweep, ready always high.
    b0 = busy_cyc; q0 = wq.size();
    start_sweep(2'd0);
    wait_done(300);
    chk("busy_rec0", busy_cyc - b0, 74);
    check_sweep(q0, 0, 18);
    chk("select_rec0", 32'(bus.select_data_record_o), 0);

    // Freeze plus backpressure on idx 3.
    count_en = 1'b1;
    tick(); tick();
    chk("en_idle", 32'(bus.comm_o[24]), 1);
    b0 = busy_cyc; q0 = wq.size();
    start_sweep(2'd0);
    stall = 0; frz_bad = 0; seen = 0;
    for (int k = 0; k < 400 && seen == 0; k++) begin
      if (stall < 5 && bus.valid_o && bus.comm_o[5:0] == 6'd3) begin
        bus.ready_i = 1'b0;
        stall++;
      end else begin
        bus.ready_i = 1'b1;
      end
      @(negedge clk);
      if (!bus.ready_i) begin
        chk("bp_data", bus.data_o, 32'hA000_0003);
        chk("bp_last", 32'(bus.last_o), 0);
      end
      if (busy) begin
        if (bus.comm_o[24]) frz_bad++;
      end else begin
        seen = 1;
        chk("frz_release", 32'(bus.comm_o[24]), 1);
      end
      tick();
    end
    bus.ready_i = 1'b1;
    chk("sweep_end", seen, 1);
    chk("stall_len", stall, 5);
    chk("frz_bad", frz_bad, 0);
    chk("busy_bp", busy_cyc - b0, 79);
    check_sweep(q0, 0, 18);
    count_en = 1'b0;
    tick();

    // Rejected start: sel=3.
    e0 = err_cnt; b0 = busy_cyc; v0 = valid_cyc;
    start_sweep(2'd3);
    tick(); tick();
    chk("rej3_err", err_cnt - e0, 1);
    chk("rej3_busy", busy_cyc - b0, 0);
    chk("rej3_valid", valid_cyc - v0, 0);

    // Rejected start: tracker absent.
    sel_nt = 2'd2; start_nt = 1'b1;
    tick();
    start_nt = 1'b0;
    tick(); tick();
    chk("rejnt_err", err_nt_cnt, 1);
    chk("rejnt_busy", busy_nt_cyc, 0);
    chk("rejnt_valid", valid_nt_cyc, 0);

    // Start pulsed mid-sweep is ignored.
    e0 = err_cnt; b0 = busy_cyc; q0 = wq.size();
    start_sweep(2'd0);
    for (int k = 0; k < 10; k++) tick();
    start_sweep(2'd3);
    wait_done(300);
    chk("ign_err", err_cnt - e0, 0);
    chk("ign_busy", busy_cyc - b0, 74);
    check_sweep(q0, 0, 18);

    // Reset at idx 7, then a record 1 sweep.
    start_sweep(2'd0);
    c = 0;
    while (!(bus.valid_o && bus.comm_o[5:0] == 6'd7) && c < 200) begin
      tick();
      c++;
    end
    chk("reach_idx7", 32'(bus.comm_o[5:0]), 7);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_reset_outputs();
    tick();
    rst = 1'b0;
    tick();
    b0 = busy_cyc; q0 = wq.size();
    start_sweep(2'd1);
    wait_done(300);
    chk("busy_rec1", busy_cyc - b0, 66);
    check_sweep(q0, 1, 16);
    chk("select_rec1", 32'(bus.select_data_record_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
